inst_fetch: RTL

//  Instruction-fetch stage: owns the architectural fetch PC and a direct-mapped instruction cache (one
//  32-bit word per line). Refills misses from the memory controller and pushes {instruction, pc} into
//  the instruction queue, one per cycle, whenever the queue grants write. Redirects on clear (branch

---
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch.sv | 105 ++++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: global control, instruction-queue push side and refill side.
// The master is the fetch stage; the slave is the queue/memory/commit environment.
interface inst_fetch_if;
    logic        rdy_in;
    logic        clear;
    logic [31:0] new_pc;
    logic        iq_wr_en;
    logic        inst_status;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport master (
        input  rdy_in, clear, new_pc, iq_wr_en, mem_done, mem_data,
        output inst_status, inst_out, pc_out, mem_req, mem_addr
    );

    modport slave (
        output rdy_in, clear, new_pc, iq_wr_en, mem_done, mem_data,
        input  inst_status, inst_out, pc_out, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch with a direct-mapped one-word-per-line I-cache; one registered push per hit cycle.
// Push 1 cycle after a hit lookup; iq_wr_en low or rdy_in low holds the pc, a miss holds mem_req until mem_done.
module inst_fetch #(
    parameter int          IDX_W    = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic         clk_in,
    input  logic         rst_in,
    inst_fetch_if.master bus
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {FETCH, MISS, FLUSH} state_t;

    state_t            state_q;
    logic [31:0]       pc_q;
    logic [31:0]       inst_q;
    logic [31:0]       pc_out_q;
    logic [31:0]       mem_addr_q;
    logic              inst_status_q;
    logic              mem_req_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       line_q [LINES];

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  fill_idx;
    logic              hit;
    logic              fill_en;
    logic [31:0]       target;

    assign idx      = pc_q[IDX_W+1:2];
    assign fill_idx = mem_addr_q[IDX_W+1:2];
    assign hit      = valid_q[idx] && (tag_q[idx] == pc_q[31:IDX_W+2]);
    // A refill completes in MISS or FLUSH alike; the data always belongs to mem_addr.
    assign fill_en  = (state_q != FETCH) && bus.rdy_in && bus.mem_done;
    assign target   = bus.new_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= mem_addr_q[31:IDX_W+2];
            line_q[fill_idx] <= bus.mem_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            valid_q       <= '0;
            inst_status_q <= 1'b0;
            inst_q        <= 32'h0;
            pc_out_q      <= 32'h0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
        end else begin
            inst_status_q <= 1'b0;
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
            if (bus.clear) begin
                pc_q <= target;
                if (state_q != FETCH) begin
                    if (fill_en) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FETCH;
                    end else begin
                        state_q   <= FLUSH;
                    end
                end
            end else if (bus.rdy_in) begin
                case (state_q)
                    FETCH: begin
                        if (hit) begin
                            if (bus.iq_wr_en) begin
                                inst_status_q <= 1'b1;
                                inst_q        <= line_q[idx];
                                pc_out_q      <= pc_q;
                                pc_q          <= pc_q + 32'd4;
                            end
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc_q;
                            state_q    <= MISS;
                        end
                    end
                    MISS, FLUSH: begin
                        if (fill_en) begin
                            mem_req_q <= 1'b0;
                            state_q   <= FETCH;
                        end
                    end
                    default: state_q <= FETCH;
                endcase
            end
        end
    end

    assign bus.inst_status = inst_status_q;
    assign bus.inst_out    = inst_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
endmodule
